// File: rtl/draw_cmd_queue.sv
// draw_cmd_queue: staging regs + cmd FIFO + issue FSM for the draw unit.
// Optional drain interrupt when DRAWQ_IRQ_EN is defined.
module draw_cmd_queue #(
  parameter int         DEPTH_LOG2 = 2,
  parameter logic [7:0] CMD_RECT   = 8'h01
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_en,
  input  logic [3:0]   wr_addr,
  input  logic [31:0]  wr_data,
  input  logic [3:0]   rd_addr,
  output logic [31:0]  rd_data,
  output logic [7:0]   du_command,
  output logic [255:0] du_data,
  output logic         du_commit,
  input  logic         du_ack,
  input  logic         du_done,
`ifdef DRAWQ_IRQ_EN
  output logic         irq,
`endif
  output logic         busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int EW    = 8 + 256;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    RECOVER
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [31:0]   stage [8];
  logic [255:0]  stage_flat;
  logic [EW-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] level;

  logic empty;
  logic full;
  logic pop;
  logic cmd_wr;
  logic ctrl_wr;
  logic flush;
  logic clr;
  logic code_ok;
  logic push_req;
  logic push_ok;
  logic push_drop;
  logic overflow;
  logic bad_cmd;
  logic [31:0] status;

`ifdef DRAWQ_IRQ_EN
  logic irq_pend;
  logic irq_clr;
  logic drain_evt;
`endif

  assign level = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                 (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);

  assign cmd_wr  = wr_en && (wr_addr == 4'd8);
  assign ctrl_wr = wr_en && (wr_addr == 4'd9);
  assign flush   = ctrl_wr && wr_data[1];
  assign clr     = ctrl_wr && wr_data[0];
  assign code_ok = (wr_data[7:0] == CMD_RECT);

  // The head leaves the FIFO in the same cycle it is loaded to du_*.
  assign pop = (state_q == IDLE) && !empty;

  // Flush beats a push; a pop frees the slot a full-FIFO push needs.
  assign push_req  = cmd_wr && code_ok && !flush;
  assign push_ok   = push_req && (!full || pop);
  assign push_drop = push_req && full && !pop;

  assign busy = !empty || (state_q != IDLE);

  // Flatten staging words into the 256-bit argument block.
  always_comb begin
    stage_flat = '0;
    for (int i = 0; i < 8; i++) begin
      stage_flat[32*i +: 32] = stage[i];
    end
  end

  // Staging registers, kept after a push so a block can be re-sent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        stage[i] <= '0;
      end
    end else if (wr_en && !wr_addr[3]) begin
      stage[wr_addr[2:0]] <= wr_data;
    end
  end

  // FIFO storage; contents are don't-care while pointers say empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[PW-2:0]] <= {wr_data[7:0], stage_flat};
    end
  end

  // FIFO pointers with an extra wrap bit to tell full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Sticky error flags, cleared by CTRL bit0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      bad_cmd  <= 1'b0;
    end else begin
      if (clr) begin
        overflow <= 1'b0;
        bad_cmd  <= 1'b0;
      end
      if (push_drop) begin
        overflow <= 1'b1;
      end
      if (cmd_wr && !code_ok) begin
        bad_cmd <= 1'b1;
      end
    end
  end

  // Issue FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Issue FSM next state: commit, ack, done, then one recovery cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (!empty) state_d = ISSUE;
      ISSUE:     if (du_ack) state_d = WAIT_DONE;
      WAIT_DONE: if (du_done) state_d = RECOVER;
      RECOVER:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Draw unit outputs: load on pop, drop commit once acked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      du_command <= '0;
      du_data    <= '0;
      du_commit  <= 1'b0;
    end else if (pop) begin
      {du_command, du_data} <= mem[rd_ptr[PW-2:0]];
      du_commit <= 1'b1;
    end else if ((state_q == ISSUE) && du_ack) begin
      du_commit <= 1'b0;
    end
  end

`ifdef DRAWQ_IRQ_EN
  assign drain_evt = (state_q == RECOVER) && empty;
  assign irq_clr   = ctrl_wr && wr_data[2];

  // One-cycle drain pulse plus a sticky pending bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq      <= 1'b0;
      irq_pend <= 1'b0;
    end else begin
      irq <= drain_evt;
      if (drain_evt) begin
        irq_pend <= 1'b1;
      end else if (irq_clr) begin
        irq_pend <= 1'b0;
      end
    end
  end
`endif

  // STATUS word assembly.
  always_comb begin
    status       = '0;
    status[7:0]  = 8'(level);
    status[8]    = empty;
    status[9]    = full;
    status[10]   = busy;
    status[11]   = overflow;
    status[12]   = bad_cmd;
`ifdef DRAWQ_IRQ_EN
    status[13]   = irq_pend;
`endif
  end

  // Combinational register read decode.
  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      !rd_addr[3]:       rd_data = stage[rd_addr[2:0]];
      rd_addr == 4'd8:   rd_data = status;
      default:           rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_draw_cmd_queue.sv
// tb_draw_cmd_queue: scoreboard bench for draw_cmd_queue.
// Expected commits are queued on push and popped on du_commit rise.
module tb_draw_cmd_queue;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_en = 1'b0;
  logic [3:0]   wr_addr = '0;
  logic [31:0]  wr_data = '0;
  logic [3:0]   rd_addr = '0;
  logic [31:0]  rd_data;
  logic [7:0]   du_command;
  logic [255:0] du_data;
  logic         du_commit;
  logic         du_ack = 1'b0;
  logic         du_done = 1'b0;
  logic         busy;
`ifdef DRAWQ_IRQ_EN
  logic         irq;
`endif

  typedef logic [263:0] ent_t;

  int          n_cmp = 0;
  int          n_err = 0;
  ent_t        sb[$];
  logic [31:0] st[8];
  logic        prev_c = 1'b0;

  draw_cmd_queue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .du_command (du_command),
    .du_data    (du_data),
    .du_commit  (du_commit),
    .du_ack     (du_ack),
    .du_done    (du_done),
`ifdef DRAWQ_IRQ_EN
    .irq        (irq),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every commit rise must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && du_commit && !prev_c) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL commit_unexpected got=%h exp=none",
                 {du_command, du_data});
      end else begin
        ent_t e;
        e = sb.pop_front();
        if ({du_command, du_data} !== e) begin
          n_err++;
          $display("FAIL commit_order got=%h exp=%h",
                   {du_command, du_data}, e);
        end
      end
    end
    prev_c = du_commit;
  end

  function automatic ent_t mk(input logic [7:0] c);
    ent_t e;
    e[263:256] = c;
    for (int i = 0; i < 8; i++) begin
      e[32*i +: 32] = st[i];
    end
    return e;
  endfunction

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic set_stage(input int i, input logic [31:0] d);
    wr(4'(i), d);
    st[i] = d;
  endtask

  task automatic rd_status(output logic [31:0] s);
    rd_addr = 4'd8;
    #1;
    s = rd_data;
  endtask

  task automatic pulse_ack;
    du_ack = 1'b1;
    @(negedge clk);
    du_ack = 1'b0;
  endtask

  task automatic pulse_done;
    du_done = 1'b1;
    @(negedge clk);
    du_done = 1'b0;
  endtask

  task automatic wait_commit(output bit ok);
    int k;
    k = 0;
    while (du_commit !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    ok = (du_commit === 1'b1);
  endtask

  task automatic drain(input int n, output bit ok);
    bit o;
    ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      wait_commit(o);
      if (!o) ok = 1'b0;
      pulse_ack();
      pulse_done();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [31:0] s;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rd_status(s);
    n_cmp++;
    if (s !== 32'h100) begin
      n_err++;
      $display("FAIL reset_status got=%h exp=%h", s, 32'h100);
    end
    n_cmp++;
    if (du_commit !== 1'b0 || du_command !== 8'h0) begin
      n_err++;
      $display("FAIL reset_du got=%b/%h exp=0/00",
               du_commit, du_command);
    end
    n_cmp++;
    if (du_data !== 256'h0) begin
      n_err++;
      $display("FAIL reset_data got=%h exp=0", du_data);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
    rd_addr = 4'd3;
    #1;
    n_cmp++;
    if (rd_data !== 32'h0) begin
      n_err++;
      $display("FAIL reset_stage got=%h exp=0", rd_data);
    end
    for (int i = 0; i < 8; i++) st[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single;
    logic [31:0] s;
    set_stage(0, 32'h0050_0A0A);
    set_stage(1, 32'h0000_F800);
    rd_addr = 4'd1;
    #1;
    n_cmp++;
    if (rd_data !== 32'h0000_F800) begin
      n_err++;
      $display("FAIL stage_read got=%h exp=%h", rd_data, 32'h0000_F800);
    end
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = 4'd8;
    wr_data = 32'h1;
    sb.push_back(mk(8'h01));
    @(negedge clk);
    wr_en = 1'b0;
    n_cmp++;
    if (du_commit !== 1'b0) begin
      n_err++;
      $display("FAIL commit_early got=%b exp=0", du_commit);
    end
    @(negedge clk);
    n_cmp++;
    if (du_commit !== 1'b1) begin
      n_err++;
      $display("FAIL commit_latency got=%b exp=1", du_commit);
    end
    n_cmp++;
    if (du_data[63:0] !== 64'h0000_F800_0050_0A0A) begin
      n_err++;
      $display("FAIL single_data got=%h exp=%h",
               du_data[63:0], 64'h0000_F800_0050_0A0A);
    end
    n_cmp++;
    if (du_command !== 8'h01) begin
      n_err++;
      $display("FAIL single_cmd got=%h exp=01", du_command);
    end
    pulse_ack();
    n_cmp++;
    if (du_commit !== 1'b0) begin
      n_err++;
      $display("FAIL commit_drop got=%b exp=0", du_commit);
    end
    pulse_done();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL busy_recover got=%b exp=1", busy);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL busy_idle got=%b exp=0", busy);
    end
`ifdef DRAWQ_IRQ_EN
    n_cmp++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL irq_pulse got=%b exp=1", irq);
    end
    rd_status(s);
    n_cmp++;
    if (s[13] !== 1'b1) begin
      n_err++;
      $display("FAIL irq_pend got=%b exp=1", s[13]);
    end
    @(negedge clk);
    n_cmp++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL irq_width got=%b exp=0", irq);
    end
    wr(4'd9, 32'h4);
    rd_status(s);
    n_cmp++;
    if (s[13] !== 1'b0) begin
      n_err++;
      $display("FAIL irq_clear got=%b exp=0", s[13]);
    end
`else
    rd_status(s);
    n_cmp++;
    if (s !== 32'h100) begin
      n_err++;
      $display("FAIL single_idle got=%h exp=%h", s, 32'h100);
    end
`endif
  endtask

  task automatic test_fill;
    logic [31:0] s;
    bit ok;
    for (int k = 0; k < 6; k++) begin
      set_stage(2, 32'hA0 + 32'(k));
      wr(4'd8, 32'h1);
      if (k < 5) sb.push_back(mk(8'h01));
      if (k == 4) begin
        rd_status(s);
        n_cmp++;
        if (s[7:0] !== 8'd4 || s[9] !== 1'b1) begin
          n_err++;
          $display("FAIL fill_full got=%h exp=lvl4,full", s);
        end
      end
    end
    rd_status(s);
    n_cmp++;
    if (s[11] !== 1'b1 || s[7:0] !== 8'd4) begin
      n_err++;
      $display("FAIL fill_overflow got=%h exp=ovf,lvl4", s);
    end
    pulse_ack();
    n_cmp++;
    if (du_commit !== 1'b0) begin
      n_err++;
      $display("FAIL fill_ack got=%b exp=0", du_commit);
    end
    wr(4'd9, 32'h1);
    rd_status(s);
    n_cmp++;
    if (s[11] !== 1'b0 || s[7:0] !== 8'd4) begin
      n_err++;
      $display("FAIL ovf_clear got=%h exp=noovf,lvl4", s);
    end
    pulse_done();
    drain(4, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL fill_drain got=timeout exp=4 commits");
    end
    rd_status(s);
    n_cmp++;
    if (s[12:0] !== 13'h100) begin
      n_err++;
      $display("FAIL fill_end got=%h exp=%h", s[12:0], 13'h100);
    end
  endtask

  task automatic test_bad_code;
    logic [31:0] s;
    wr(4'd8, 32'h7);
    repeat (2) @(negedge clk);
    rd_status(s);
    n_cmp++;
    if (s[7:0] !== 8'd0 || s[12] !== 1'b1) begin
      n_err++;
      $display("FAIL bad_code got=%h exp=lvl0,bad", s);
    end
    n_cmp++;
    if (du_commit !== 1'b0) begin
      n_err++;
      $display("FAIL bad_commit got=%b exp=0", du_commit);
    end
    wr(4'd9, 32'h1);
    rd_status(s);
    n_cmp++;
    if (s[12] !== 1'b0) begin
      n_err++;
      $display("FAIL bad_clear got=%b exp=0", s[12]);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    int gap;
    for (int k = 0; k < 3; k++) begin
      set_stage(0, 32'hB0B0_0000 + 32'(k));
      wr(4'd8, 32'h1);
      sb.push_back(mk(8'h01));
    end
    for (int k = 0; k < 3; k++) begin
      wait_commit(ok);
      n_cmp++;
      if (!ok) begin
        n_err++;
        $display("FAIL b2b_commit got=timeout exp=commit %0d", k);
      end
      pulse_ack();
      pulse_done();
      if (k < 2) begin
        gap = 0;
        while (du_commit !== 1'b1 && gap < 10) begin
          @(negedge clk);
          gap++;
        end
        n_cmp++;
        if (gap != 2) begin
          n_err++;
          $display("FAIL b2b_gap got=%0d exp=2", gap);
        end
      end else begin
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
          n_err++;
          $display("FAIL b2b_idle got=%b exp=0", busy);
        end
      end
    end
  endtask

  task automatic test_simul;
    logic [31:0] s;
    bit ok;
    set_stage(0, 32'h11);
    wr(4'd8, 32'h1);
    sb.push_back(mk(8'h01));
    wait_commit(ok);
    pulse_ack();
    for (int k = 0; k < 4; k++) begin
      set_stage(0, 32'h12 + 32'(k));
      wr(4'd8, 32'h1);
      sb.push_back(mk(8'h01));
    end
    set_stage(0, 32'h16);
    pulse_done();
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = 4'd8;
    wr_data = 32'h1;
    sb.push_back(mk(8'h01));
    @(negedge clk);
    wr_en = 1'b0;
    rd_status(s);
    n_cmp++;
    if (s[7:0] !== 8'd4 || s[9] !== 1'b1 || s[11] !== 1'b0) begin
      n_err++;
      $display("FAIL pushpop got=%h exp=lvl4,full,noovf", s);
    end
    n_cmp++;
    if (du_commit !== 1'b1) begin
      n_err++;
      $display("FAIL pushpop_commit got=%b exp=1", du_commit);
    end
    drain(5, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL pushpop_drain got=timeout exp=5 commits");
    end
    set_stage(0, 32'h21);
    wr(4'd8, 32'h1);
    sb.push_back(mk(8'h01));
    wait_commit(ok);
    pulse_ack();
    set_stage(0, 32'h22);
    wr(4'd8, 32'h1);
    set_stage(0, 32'h23);
    wr(4'd8, 32'h1);
    rd_status(s);
    n_cmp++;
    if (s[7:0] !== 8'd2) begin
      n_err++;
      $display("FAIL preflush_lvl got=%0d exp=2", s[7:0]);
    end
    wr(4'd9, 32'h2);
    rd_status(s);
    n_cmp++;
    if (s[10:0] !== 11'h500) begin
      n_err++;
      $display("FAIL flush got=%h exp=%h", s[10:0], 11'h500);
    end
    pulse_done();
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL flush_idle got=%b exp=0", busy);
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (du_commit !== 1'b0) begin
      n_err++;
      $display("FAIL flush_nocommit got=%b exp=0", du_commit);
    end
  endtask

  task automatic test_async_reset;
    logic [31:0] s;
    bit ok;
    set_stage(0, 32'h31);
    wr(4'd8, 32'h1);
    sb.push_back(mk(8'h01));
    wait_commit(ok);
    pulse_ack();
    set_stage(0, 32'h32);
    wr(4'd8, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    rd_status(s);
    n_cmp++;
    if (s !== 32'h100) begin
      n_err++;
      $display("FAIL arst_status got=%h exp=%h", s, 32'h100);
    end
    n_cmp++;
    if (du_commit !== 1'b0 || du_command !== 8'h0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL arst_out got=%b/%h/%b exp=0/00/0",
               du_commit, du_command, busy);
    end
    for (int i = 0; i < 8; i++) st[i] = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    rd_status(s);
    n_cmp++;
    if (du_commit !== 1'b0 || s !== 32'h100) begin
      n_err++;
      $display("FAIL arst_quiet got=%b/%h exp=0/%h",
               du_commit, s, 32'h100);
    end
    wr(4'd8, 32'h1);
    sb.push_back(mk(8'h01));
    wait_commit(ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL arst_repush got=timeout exp=commit");
    end
    pulse_ack();
    pulse_done();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_bad_code();
    test_back_to_back();
    test_simul();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
